// File: rtl/aes_pkg.sv
// Shared AES definitions: GF(2^8) helpers, column type and MixColumns engine FSM states.
// Imported by the column unit and the MixColumns engine.
package aes_pkg;

  localparam logic [7:0] AES_POLY = 8'h1b;

  // Element 0 is row 0, the most significant byte of the 32-bit column.
  typedef logic [0:3][7:0] col_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mc_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul2(input logic [7:0] x);
    return xtime(x);
  endfunction

  // Multiply by a 4-bit constant; covers every MixColumns coefficient (1,2,3,9,b,d,e).
  function automatic logic [7:0] gf_mul_k(input logic [7:0] x, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = gf_mul2(x);
    x4 = gf_mul2(x2);
    x8 = gf_mul2(x4);
    return ({8{k[0]}} & x) ^ ({8{k[1]}} & x2) ^ ({8{k[2]}} & x4) ^ ({8{k[3]}} & x8);
  endfunction

endpackage

// File: rtl/mixcol_engine_if.sv
// Block-level handshake bundle for the MixColumns engine: upstream valid/ready,
// downstream valid/ready, 128-bit state in both directions and a busy flag.
interface mixcol_engine_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_i;
  logic         decrypt_i;
  logic         bypass_i;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] data_o;
  logic         busy_o;

  modport master (
    output in_valid, data_i, decrypt_i, bypass_i, out_ready,
    input  in_ready, out_valid, data_o, busy_o
  );

  modport slave (
    input  in_valid, data_i, decrypt_i, bypass_i, out_ready,
    output in_ready, out_valid, data_o, busy_o
  );
endinterface

// File: rtl/mixcol_word.sv
// One-column MixColumns / InvMixColumns, purely combinational.
module mixcol_word
  import aes_pkg::*;
(
  input  col_t col_i,
  input  logic decrypt_i,
  output col_t col_o
);

  // Row r uses a rotated coefficient row; 2-bit index arithmetic gives mod-4 wrap.
  always_comb begin
    col_o = '0;
    for (int r = 0; r < 4; r++) begin
      if (decrypt_i)
        col_o[r] = gf_mul_k(col_i[2'(r)],     4'he) ^ gf_mul_k(col_i[2'(r + 1)], 4'hb) ^
                   gf_mul_k(col_i[2'(r + 2)], 4'hd) ^ gf_mul_k(col_i[2'(r + 3)], 4'h9);
      else
        col_o[r] = gf_mul_k(col_i[2'(r)],     4'h2) ^ gf_mul_k(col_i[2'(r + 1)], 4'h3) ^
                   col_i[2'(r + 2)] ^ col_i[2'(r + 3)];
    end
  end

endmodule

// File: rtl/mixcol_engine.sv
// Iterative AES MixColumns / InvMixColumns with per-block bypass, COLS_PER_CYC columns per beat.
// Result is held in data_o until consumed; a new block may be accepted on the hand-off cycle.
module mixcol_engine
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYC = 1
) (
  input  logic           clk,
  input  logic           rst,
  mixcol_engine_if.slave bus
);

  localparam int NBEAT = 4 / COLS_PER_CYC;
  localparam int BW    = (NBEAT > 1) ? $clog2(NBEAT) : 1;

  if (COLS_PER_CYC != 1 && COLS_PER_CYC != 2 && COLS_PER_CYC != 4) begin : g_bad_cols
    $error("mixcol_engine: COLS_PER_CYC must be 1, 2 or 4");
  end

  mc_state_e     state_q, state_d;
  logic [BW-1:0] beat_q;
  logic [127:0]  din_q;
  logic [127:0]  dout_q;
  logic          dec_q;
  logic          accept;
  logic          last_beat;

  col_t col_in  [COLS_PER_CYC];
  col_t col_out [COLS_PER_CYC];

  assign last_beat = (beat_q == BW'(NBEAT - 1));
  assign accept    = bus.in_valid && bus.in_ready;

  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_d = bus.bypass_i ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        if (last_beat) state_d = ST_DONE;
      end
      ST_DONE: begin
        bus.out_valid = 1'b1;
        bus.in_ready  = bus.out_ready;
        if (bus.out_ready)
          state_d = bus.in_valid ? (bus.bypass_i ? ST_DONE : ST_RUN) : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  for (genvar g = 0; g < COLS_PER_CYC; g++) begin : g_col
    always_comb col_in[g] = din_q[127 - 32 * (int'(beat_q) * COLS_PER_CYC + g) -: 32];

    mixcol_word u_word (
      .col_i     (col_in[g]),
      .decrypt_i (dec_q),
      .col_o     (col_out[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      din_q   <= '0;
      dout_q  <= '0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        din_q  <= bus.data_i;
        dec_q  <= bus.decrypt_i;
        beat_q <= '0;
        if (bus.bypass_i) dout_q <= bus.data_i;
      end else if (state_q == ST_RUN) begin
        for (int g = 0; g < COLS_PER_CYC; g++)
          dout_q[127 - 32 * (int'(beat_q) * COLS_PER_CYC + g) -: 32] <= col_out[g];
        beat_q <= last_beat ? '0 : beat_q + 1'b1;
      end
    end
  end

  assign bus.data_o = dout_q;
  assign bus.busy_o = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mixcol_engine.sv
// Drives identical traffic into three engines (1, 2 and 4 columns per cycle) and
// checks results and latencies against a byte-level GF(2^8) matrix model.
module tb_mixcol_engine;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         in_valid, decrypt, bypass, out_ready;
  logic [127:0] data_in;

  mixcol_engine_if if1 ();
  mixcol_engine_if if2 ();
  mixcol_engine_if if4 ();

  assign if1.in_valid = in_valid;  assign if2.in_valid = in_valid;  assign if4.in_valid = in_valid;
  assign if1.data_i   = data_in;   assign if2.data_i   = data_in;   assign if4.data_i   = data_in;
  assign if1.decrypt_i = decrypt;  assign if2.decrypt_i = decrypt;  assign if4.decrypt_i = decrypt;
  assign if1.bypass_i = bypass;    assign if2.bypass_i = bypass;    assign if4.bypass_i = bypass;
  assign if1.out_ready = out_ready; assign if2.out_ready = out_ready; assign if4.out_ready = out_ready;

  mixcol_engine #(.COLS_PER_CYC(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  mixcol_engine #(.COLS_PER_CYC(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));
  mixcol_engine #(.COLS_PER_CYC(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));

  logic         ov [3];
  logic         ir [3];
  logic         bz [3];
  logic [127:0] dq [3];

  assign ov[0] = if1.out_valid; assign ov[1] = if2.out_valid; assign ov[2] = if4.out_valid;
  assign ir[0] = if1.in_ready;  assign ir[1] = if2.in_ready;  assign ir[2] = if4.in_ready;
  assign bz[0] = if1.busy_o;    assign bz[1] = if2.busy_o;    assign bz[2] = if4.busy_o;
  assign dq[0] = if1.data_o;    assign dq[1] = if2.data_o;    assign dq[2] = if4.data_o;

  int checks   = 0;
  int failures = 0;
  int lat_run [3] = '{5, 3, 2};

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_model(input logic [127:0] d, input logic dec, input logic byp);
    logic [127:0] res = '0;
    logic [7:0]   k [4];
    logic [7:0]   acc;
    if (byp) return d;
    if (dec) k = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     k = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int i = 0; i < 4; i++)
          acc = acc ^ gmul(d[127 - 32*c - 8*((r + i) % 4) -: 8], k[i]);
        res[127 - 32*c - 8*r -: 8] = acc;
      end
    return res;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called right after the accept edge; that edge counts as latency cycle 1.
  task automatic collect(input string tag, input logic [127:0] exp, input logic byp);
    int edges = 1;
    bit got [3] = '{1'b0, 1'b0, 1'b0};
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++)
        if (!got[i] && ov[i]) begin
          got[i] = 1'b1;
          chk($sformatf("%s_lat%0d", tag, i), 128'(edges), 128'(byp ? 1 : lat_run[i]));
          chk($sformatf("%s_data%0d", tag, i), dq[i], exp);
        end
      if (got[0] && got[1] && got[2]) break;
      @(posedge clk);
      edges++;
    end
    for (int i = 0; i < 3; i++) chk($sformatf("%s_done%0d", tag, i), 128'(got[i]), 128'd1);
  endtask

  task automatic send(input string tag, input logic [127:0] d, input logic dec, input logic byp,
                      input logic [127:0] exp);
    data_in  = d;
    decrypt  = dec;
    bypass   = byp;
    in_valid = 1'b1;
    @(posedge clk);
    collect(tag, exp, byp);
  endtask

  task automatic chk_reset_values(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_in_ready%0d", tag, i), 128'(ir[i]), 128'd1);
      chk($sformatf("%s_out_valid%0d", tag, i), 128'(ov[i]), 128'd0);
      chk($sformatf("%s_busy%0d", tag, i), 128'(bz[i]), 128'd0);
      chk($sformatf("%s_data%0d", tag, i), dq[i], 128'd0);
    end
  endtask

  logic [127:0] b1, b2, rnd;
  logic         rdec, rbyp;

  initial begin
    rst = 1'b1; in_valid = 1'b0; decrypt = 1'b0; bypass = 1'b0; out_ready = 1'b1; data_in = '0;
    repeat (2) @(negedge clk);
    chk_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);

    send("fips_enc", 128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0, 1'b0,
         128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);
    send("fips_dec", 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b1, 1'b0,
         128'hdb135345_f20a225c_01010101_c6c6c6c6);
    send("bypass", 128'h00112233_44556677_8899aabb_ccddeeff, 1'b0, 1'b1,
         128'h00112233_44556677_8899aabb_ccddeeff);

    for (int n = 0; n < 16; n++) begin
      rnd  = {$urandom, $urandom, $urandom, $urandom};
      rdec = 1'($urandom_range(0, 1));
      rbyp = ($urandom_range(0, 3) == 0);
      send($sformatf("rnd%0d", n), rnd, rdec, rbyp, ref_model(rnd, rdec, rbyp));
    end

    // Backpressure: first block parks in DONE, a second request waits on in_valid.
    b1 = {$urandom, $urandom, $urandom, $urandom};
    b2 = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    out_ready = 1'b0;
    data_in = b1; decrypt = 1'b0; bypass = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    data_in = b2; decrypt = 1'b1;
    repeat (5) @(negedge clk);
    for (int n = 0; n < 10; n++) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("bp_valid%0d", i), 128'(ov[i]), 128'd1);
        chk($sformatf("bp_data%0d", i), dq[i], ref_model(b1, 1'b0, 1'b0));
        chk($sformatf("bp_in_ready%0d", i), 128'(ir[i]), 128'd0);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) chk($sformatf("b2b_in_ready%0d", i), 128'(ir[i]), 128'd1);
    @(posedge clk);
    collect("b2b", ref_model(b2, 1'b1, 1'b0), 1'b0);

    // Reset in the middle of a block (the 1-column engine is at beat 2).
    @(negedge clk);
    rnd = {$urandom, $urandom, $urandom, $urandom};
    data_in = rnd; decrypt = 1'b0; bypass = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset_values("midrst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rnd = {$urandom, $urandom, $urandom, $urandom};
    send("post_rst", rnd, 1'b0, 1'b0, ref_model(rnd, 1'b0, 1'b0));

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
